bram_stream_port: RTL and testbench

- Initiator-side controller for the 1K x 32 single-ported block RAM wrapper (read latency 1, WRITE_FIRST, enable-gated).
- Accepts one burst command at a time: a start address and a length.
- Write bursts move words from an input stream into the RAM. Read bursts move words from the RAM onto an output stream, with full valid/ready backpressure.
- Sits between a core-side DMA/ring client and the RAM port.

---
 rtl/bram_stream_pkg.sv | 22 ++
 rtl/bram_stream_port_fifo2.sv | 62 ++++++
 rtl/bram_stream_port.sv | 161 ++++++++++++++++
 tb/tb_bram_stream_port.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_stream_pkg.sv
// rtl/bram_stream_pkg.sv - shared widths, constants and FSM encoding for the BRAM stream port
package bram_stream_pkg;

    localparam int DEF_AW = 10;
    localparam int DEF_DW = 32;
    localparam int DEF_LW = 11;

    // The RAM returns read data the cycle after an enabled read, so a single
    // inflight flag is enough to track an outstanding read.
    localparam int RAM_RD_LATENCY = 1;

    // Depth of the read-return skid buffer; also the read issue credit.
    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/bram_stream_port_fifo2.sv
// rtl/bram_stream_port_fifo2.sv - two-entry skid FIFO holding RAM read returns
module bram_skid_fifo2 #(
    parameter int DW = 32
) (
    input  logic          clka,
    input  logic          rsta_n,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [1:0]    count
);

    // head_q drives the output directly so m_tdata is a register and holds
    // while the consumer stalls; tail_q is only occupied when head_q is.
    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic          head_v;
    logic          tail_v;
    logic          pop;
    logic          push;

    // The producer throttles on count, so a push never lands on a full buffer.
    assign push     = s_tvalid;
    assign pop      = head_v && m_tready;
    assign m_tdata  = head_q;
    assign m_tvalid = head_v;
    assign count    = {tail_v, head_v & ~tail_v};

    // Shift tail into head on a pop, and place a push in the first free slot.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else begin
            if (pop) begin
                if (tail_v) begin
                    head_q <= tail_q;
                    if (push) begin
                        tail_q <= s_tdata;
                    end else begin
                        tail_v <= 1'b0;
                    end
                end else if (push) begin
                    head_q <= s_tdata;
                end else begin
                    head_v <= 1'b0;
                end
            end else if (push) begin
                if (!head_v) begin
                    head_q <= s_tdata;
                    head_v <= 1'b1;
                end else begin
                    tail_q <= s_tdata;
                    tail_v <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bram_stream_port.sv
// rtl/bram_stream_port.sv - burst command controller moving stream words to and from a single-port BRAM
module bram_stream_port
    import bram_stream_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int LW = DEF_LW
) (
    input  logic          clka,
    input  logic          rsta_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          done,
    output logic [AW-1:0] bram_addra,
    output logic [DW-1:0] bram_dina,
    output logic          bram_wea,
    output logic          bram_ena,
    input  logic [DW-1:0] bram_douta
);

    localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] remaining;
    logic          cmd_ready_q;
    logic          wr_ready_q;
    logic          done_q;
    logic          inflight;

    logic [LW-1:0] len_eff;
    logic          cmd_fire;
    logic          first_issue;
    logic          wr_fire;
    logic          rd_pop;
    logic          rd_issue_run;
    logic          rd_issue;
    logic          drain_done;
    logic [1:0]    buf_count;
    logic [2:0]    occ;

    // Lengths beyond the RAM depth are clamped; a full-depth burst touches every word once.
    assign len_eff  = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
    assign cmd_fire = cmd_valid && cmd_ready_q;

    // The first read goes out in the handshake cycle itself, which puts the
    // first word on rd_data two cycles after the command is taken.
    assign first_issue = cmd_fire && !cmd_write && (len_eff != '0);

    assign wr_fire = (state == WRITE) && wr_valid && wr_ready_q;
    assign rd_pop  = rd_valid && rd_ready;

    // Buffer slots already claimed: stored words plus the read in flight,
    // less the word leaving this cycle (its slot is free again at the edge
    // where the next issue's data could at the earliest arrive).
    assign occ = 3'(buf_count) + 3'(inflight) - 3'(rd_pop);

    assign rd_issue_run = (state == READ) && (remaining != '0) && (occ < 3'(RD_BUF_DEPTH));
    assign rd_issue     = first_issue || rd_issue_run;

    // Last word has left the buffer (or is leaving now) and nothing is in flight.
    assign drain_done = (state == DRAIN) && !inflight && (occ == 3'd0);

    assign bram_ena   = wr_fire || rd_issue;
    assign bram_wea   = wr_fire;
    assign bram_addra = (state == IDLE) ? cmd_addr : cur_addr;
    assign bram_dina  = wr_data;

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign done      = done_q;

    bram_skid_fifo2 #(
        .DW (DW)
    ) u_rd_buf (
        .clka     (clka),
        .rsta_n   (rsta_n),
        .s_tdata  (bram_douta),
        .s_tvalid (inflight),
        .m_tdata  (rd_data),
        .m_tvalid (rd_valid),
        .m_tready (rd_ready),
        .count    (buf_count)
    );

    // Burst FSM: command capture, address/length counting and completion pulse.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            remaining   <= '0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            inflight    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= rd_issue;
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        if (len_eff == '0) begin
                            done_q <= 1'b1;
                        end else if (cmd_write) begin
                            state       <= WRITE;
                            cur_addr    <= cmd_addr;
                            remaining   <= len_eff;
                            cmd_ready_q <= 1'b0;
                            wr_ready_q  <= 1'b1;
                        end else begin
                            cur_addr    <= cmd_addr + 1'b1;
                            remaining   <= len_eff - 1'b1;
                            cmd_ready_q <= 1'b0;
                            state       <= (len_eff == LW'(1)) ? DRAIN : READ;
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LW'(1)) begin
                            wr_ready_q  <= 1'b0;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        cur_addr  <= cur_addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LW'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_port.sv
// tb/tb_bram_stream_port.sv - directed self-checking bench for bram_stream_port
module tb_bram_stream_port;

    logic        clka = 1'b0;
    logic        rsta_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        done;
    logic [9:0]  bram_addra;
    logic [31:0] bram_dina;
    logic        bram_wea;
    logic        bram_ena;
    logic [31:0] bram_douta;

    logic [31:0] ram [0:1023];
    logic [31:0] exp_mem [0:1023];
    logic [31:0] wvals [0:15];

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int hs_cyc, last_acc_cyc, last_pop_cyc, first_rv_cyc, done_cyc;
    int ena_cnt, issued, delivered, done_cnt, wea_err, credit_err, stall_err, stall_cycles;
    bit fired, stalled;
    logic [15:0] rdy_mask;
    logic [31:0] stall_data;
    logic [31:0] rd_q[$];
    logic [9:0]  wlog[$];

    bram_stream_port dut (
        .clka       (clka),
        .rsta_n     (rsta_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .done       (done),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_wea   (bram_wea),
        .bram_ena   (bram_ena),
        .bram_douta (bram_douta)
    );

    always #5 clka = ~clka;

    // 1K x 32 single-port RAM: read latency 1, write-first, enable-gated.
    always @(posedge clka) begin
        if (bram_ena) begin
            if (bram_wea) begin
                ram[bram_addra] <= bram_dina;
                bram_douta      <= bram_dina;
            end else begin
                bram_douta <= ram[bram_addra];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        ena_cnt = 0; issued = 0; delivered = 0; done_cnt = 0;
        wea_err = 0; credit_err = 0; stall_err = 0; stall_cycles = 0;
        stalled = 0; hs_cyc = -1; last_acc_cyc = -1; last_pop_cyc = -1;
        first_rv_cyc = -1; done_cyc = -1;
        rd_q.delete();
        wlog.delete();
    endtask

    // One clock: drive rd_ready, sample everything mid-cycle, then step past the edge.
    task automatic clk_cycle();
        rd_ready = rdy_mask[cyc % 16];
        #1;
        if (cmd_valid && cmd_ready) hs_cyc = cyc;
        fired = wr_valid && wr_ready;
        if (fired) last_acc_cyc = cyc;
        if (bram_wea && !fired) wea_err++;
        if (bram_ena) ena_cnt++;
        if (bram_ena && bram_wea) wlog.push_back(bram_addra);
        if (bram_ena && !bram_wea) issued++;
        if (rd_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (rd_valid && rd_ready) begin
            rd_q.push_back(rd_data);
            delivered++;
            last_pop_cyc = cyc;
        end
        if (issued - delivered > 2) credit_err++;
        if (stalled && (!rd_valid || rd_data !== stall_data)) stall_err++;
        stalled    = rd_valid && !rd_ready;
        stall_data = rd_data;
        if (stalled) stall_cycles++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clka);
        #1;
        cyc++;
    endtask

    task automatic send_cmd(input logic w, input logic [9:0] a, input logic [10:0] n);
        int guard = 0;
        cmd_write = w; cmd_addr = a; cmd_len = n; cmd_valid = 1'b1;
        hs_cyc = -1;
        while (hs_cyc < 0 && guard < 20) begin
            clk_cycle();
            guard++;
        end
        cmd_valid = 1'b0;
        check("cmd_handshake", 32'(hs_cyc >= 0), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int g = 0;
        while (done_cnt == 0 && g < budget) begin
            clk_cycle();
            g++;
        end
        clk_cycle();
        clk_cycle();
        check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic run_write(input logic [9:0] a, input int n, input logic [15:0] mask);
        int k = 0;
        int g = 0;
        send_cmd(1'b1, a, 11'(n));
        while (k < n && g < 100) begin
            wr_valid = mask[g % 16];
            wr_data  = wvals[k];
            clk_cycle();
            if (fired) k++;
            g++;
        end
        wr_valid = 1'b0;
        for (int j = 0; j < n; j++) exp_mem[10'(int'(a) + j)] = wvals[j];
    endtask

    initial begin
        rsta_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; rdy_mask = 16'hFFFF;
        clear_stats();

        // Reset state
        clk_cycle();
        clk_cycle();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ena", 32'(bram_ena), 32'd0);
        check("rst_wea", 32'(bram_wea), 32'd0);
        rsta_n = 1'b1;
        clk_cycle();
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write 0x010, len 4, A0..A3 with wr_valid held
        for (int i = 0; i < 4; i++) wvals[i] = 32'hA0 + 32'(i);
        clear_stats();
        run_write(10'h010, 4, 16'hFFFF);
        wait_done("wr4", 20);
        check("wr4_last_accept", 32'(last_acc_cyc - hs_cyc), 32'd4);
        check("wr4_done_lat", 32'(done_cyc - last_acc_cyc), 32'd1);
        check("wr4_ena_cnt", 32'(ena_cnt), 32'd4);
        check("wr4_addr0", 32'(wlog[0]), 32'h010);
        check("wr4_addr3", 32'(wlog[3]), 32'h013);
        check("wr4_ram", ram[10'h012], 32'hA2);

        // Read it back with rd_ready held
        clear_stats();
        send_cmd(1'b0, 10'h010, 11'd4);
        wait_done("rd4", 20);
        check("rd4_count", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("rd4_data%0d", i), rd_q[i], 32'hA0 + 32'(i));
        check("rd4_first_valid", 32'(first_rv_cyc - hs_cyc), 32'd2);
        check("rd4_last_pop", 32'(last_pop_cyc - hs_cyc), 32'd5);
        check("rd4_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);
        check("rd4_ena_cnt", 32'(ena_cnt), 32'd4);

        // Read backpressure: 8 words at 0x200 with a 1,0,0,1,... ready pattern
        for (int i = 0; i < 8; i++) wvals[i] = 32'hC0DE_0000 + 32'(i);
        clear_stats();
        run_write(10'h200, 8, 16'hFFFF);
        wait_done("wr8", 20);
        clear_stats();
        rdy_mask = 16'b0110_1011_0011_1001;
        send_cmd(1'b0, 10'h200, 11'd8);
        wait_done("bp", 100);
        rdy_mask = 16'hFFFF;
        check("bp_count", 32'(rd_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) check($sformatf("bp_data%0d", i), rd_q[i], 32'hC0DE_0000 + 32'(i));
        check("bp_stalls_seen", 32'(stall_cycles > 0), 32'd1);
        check("bp_stable", 32'(stall_err), 32'd0);
        check("bp_credit", 32'(credit_err), 32'd0);
        check("bp_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);

        // Wrap-around write and read
        for (int i = 0; i < 4; i++) wvals[i] = 32'(i + 1);
        clear_stats();
        run_write(10'h3FE, 4, 16'hFFFF);
        wait_done("wrap_wr", 20);
        check("wrap_addr0", 32'(wlog[0]), 32'h3FE);
        check("wrap_addr1", 32'(wlog[1]), 32'h3FF);
        check("wrap_addr2", 32'(wlog[2]), 32'h000);
        check("wrap_addr3", 32'(wlog[3]), 32'h001);
        clear_stats();
        send_cmd(1'b0, 10'h3FE, 11'd4);
        wait_done("wrap_rd", 20);
        for (int i = 0; i < 4; i++) check($sformatf("wrap_rd%0d", i), rd_q[i], 32'(i + 1));

        // Zero-length commands, both directions
        for (int w = 0; w < 2; w++) begin
            clear_stats();
            send_cmd(w[0], 10'h055, 11'd0);
            wait_done("zero", 4);
            check("zero_no_ena", 32'(ena_cnt), 32'd0);
            check("zero_done_lat", 32'(done_cyc - hs_cyc), 32'd1);
            check("zero_cmd_ready", 32'(cmd_ready), 32'd1);
        end

        // Oversized length clamps to 1024 words
        clear_stats();
        send_cmd(1'b0, 10'h010, 11'h7FF);
        wait_done("clamp", 1200);
        check("clamp_count", 32'(rd_q.size()), 32'd1024);
        check("clamp_last_pop", 32'(last_pop_cyc - hs_cyc), 32'd1025);
        check("clamp_w0", rd_q[0], exp_mem[10'h010]);
        check("clamp_w3", rd_q[3], exp_mem[10'h013]);
        check("clamp_w200", rd_q[10'h1F0], exp_mem[10'h200]);
        check("clamp_w3fe", rd_q[1006], exp_mem[10'h3FE]);
        check("clamp_w001", rd_q[1009], exp_mem[10'h001]);

        // Reset in the middle of a stalled read
        clear_stats();
        rdy_mask = 16'h0000;
        send_cmd(1'b0, 10'h200, 11'd16);
        repeat (4) clk_cycle();
        check("mid_rd_valid_before", 32'(rd_valid), 32'd1);
        rsta_n = 1'b0;
        clk_cycle();
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_ena", 32'(bram_ena), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        rsta_n = 1'b1;
        repeat (3) clk_cycle();
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        clear_stats();
        rdy_mask = 16'hFFFF;
        send_cmd(1'b0, 10'h3FF, 11'd1);
        wait_done("post_rst", 20);
        check("post_rst_count", 32'(rd_q.size()), 32'd1);
        check("post_rst_data", rd_q[0], 32'd2);
        check("post_rst_done_lat", 32'(done_cyc - hs_cyc), 32'd3);

        // Write with wr_valid gaps
        wvals[0] = 32'h11; wvals[1] = 32'h22; wvals[2] = 32'h33;
        clear_stats();
        run_write(10'h0A0, 3, 16'b0000_0000_0010_0101);
        wait_done("stall_wr", 20);
        check("stall_ena_cnt", 32'(ena_cnt), 32'd3);
        check("stall_wea_gated", 32'(wea_err), 32'd0);
        check("stall_addr0", 32'(wlog[0]), 32'h0A0);
        check("stall_addr1", 32'(wlog[1]), 32'h0A1);
        check("stall_addr2", 32'(wlog[2]), 32'h0A2);
        check("stall_last_accept", 32'(last_acc_cyc - hs_cyc), 32'd6);
        check("stall_done_lat", 32'(done_cyc - last_acc_cyc), 32'd1);
        clear_stats();
        send_cmd(1'b0, 10'h0A0, 11'd3);
        wait_done("stall_rd", 20);
        check("stall_rd1", rd_q[1], 32'h22);
        check("stall_rd2", rd_q[2], 32'h33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
